// File: rtl/cpu_fetch_ctrl.sv
// Instruction fetch sequencer: single-outstanding 32-bit reads into the instruction FIFO.
// Optional fetch timeout / ERROR state is enabled by defining CPU_FETCH_TIMEOUT_EN.
// All outputs registered; request issues the cycle after its conditions hold in IDLE.
module cpu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h00001000,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        halt_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        fifo_full_i,
  output logic        fifo_write_en_o,
  output logic [31:0] fifo_data_o,
  output logic        fifo_flush_o,
  output logic        imem_req_o,
  output logic [31:0] imem_adr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_dat_i,
  output logic [31:0] fetch_pc_o,
  output logic        err_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] ERROR = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] data_q, data_d;
  logic        wen_q, wen_d;
  logic        flush_q, flush_d;
  logic [31:0] target;
  logic [31:0] pc_inc;

`ifdef CPU_FETCH_TIMEOUT_EN
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
`else
  logic        unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  // Redirect targets are word aligned; the low two bits of the target are dropped.
  assign target = {branch_target_i[31:2], 2'b00};
  assign pc_inc = pc_q + 32'd4;

  // Next-state logic for the fetch FSM and its registered outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    adr_d   = adr_q;
    data_d  = data_q;
    wen_d   = 1'b0;
    flush_d = 1'b0;
`ifdef CPU_FETCH_TIMEOUT_EN
    err_d   = err_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 8'd1;
`endif
    case (state_q)
      IDLE: begin
        if (branch_i) begin
          // Redirect also suppresses any write that would otherwise follow.
          pc_d    = target;
          flush_d = 1'b1;
        end else if (!halt_i && !fifo_full_i && !wen_q) begin
          // A pending write would occupy the slot this request's word needs.
          req_d   = 1'b1;
          adr_d   = {pc_q[31:2], 2'b00};
          state_d = WAIT;
`ifdef CPU_FETCH_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      WAIT: begin
        if (imem_ack_i) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (branch_i) begin
            pc_d    = target;
            flush_d = 1'b1;
          end else begin
            data_d  = imem_dat_i;
            wen_d   = 1'b1;
            pc_d    = pc_inc;
          end
        end else if (branch_i) begin
          // The bus cannot withdraw a request, so keep it up and discard the reply.
          pc_d    = target;
          flush_d = 1'b1;
          state_d = DRAIN;
`ifdef CPU_FETCH_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end else begin
`ifdef CPU_FETCH_TIMEOUT_EN
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CYCLES) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = ERROR;
          end
`endif
        end
      end
      DRAIN: begin
        if (branch_i) begin
          pc_d    = target;
          flush_d = 1'b1;
        end
        if (imem_ack_i) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else begin
`ifdef CPU_FETCH_TIMEOUT_EN
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CYCLES) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = ERROR;
          end
`endif
        end
      end
      ERROR: begin
`ifdef CPU_FETCH_TIMEOUT_EN
        // Only a redirect recovers from a timed-out fetch.
        if (branch_i) begin
          err_d   = 1'b0;
          pc_d    = target;
          flush_d = 1'b1;
          state_d = IDLE;
        end
`else
        // Unreachable without the timeout; fall back to IDLE.
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      adr_q   <= RESET_PC;
      data_q  <= 32'd0;
      wen_q   <= 1'b0;
      flush_q <= 1'b0;
`ifdef CPU_FETCH_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
      flush_q <= flush_d;
`ifdef CPU_FETCH_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign fifo_write_en_o = wen_q;
  assign fifo_data_o     = data_q;
  assign fifo_flush_o    = flush_q;
  assign imem_req_o      = req_q;
  assign imem_adr_o      = adr_q;
  assign fetch_pc_o      = pc_q;
`ifdef CPU_FETCH_TIMEOUT_EN
  assign err_o           = err_q;
`else
  assign err_o           = 1'b0;
`endif

endmodule
